// File: rtl/ibex_pext_mac_sequencer.sv
// ibex_pext_mac_sequencer
//   Multi-cycle sequencer for the Pext 32-bit multiply-accumulate ops
//   MADDR32, MSUBR32, KMMAC and KMMSB. One signed 17x17 multiplier is
//   time-shared across the four 16-bit partial products, which are summed
//   into a 64-bit accumulator. The final add/sub with rd is done on the
//   shared ALU adder (borrowed for one cycle in ACC). Hi ops saturate.
//
//   Optional feature macro: IBEX_PEXT_MAC_ROUND_EN
//     Adds round_i, which selects the rounding variants KMMACu/KMMSBu.
//
// Ports
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   en_i, kill_i          op request (held until valid_o) / EX flush
//   op_i                  00 MADDR32, 01 MSUBR32, 10 KMMAC, 11 KMMSB
//   operand_{a,b,c}_i     rs1, rs2, rd
//   round_i               (macro only) rounding select for hi ops
//   alu_operand_{a,b}_o   adder operands during ACC, else 0
//   alu_sub_o, alu_req_o  adder subtract select / adder request
//   alu_result_i          33-bit sign-extended adder result (same cycle)
//   result_o, ov_o        final value and saturation flag, with valid_o
//   valid_o, busy_o       completion strobe / op in flight
module ibex_pext_mac_sequencer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic        kill_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] operand_a_i,
  input  logic [31:0] operand_b_i,
  input  logic [31:0] operand_c_i,
`ifdef IBEX_PEXT_MAC_ROUND_EN
  input  logic        round_i,
`endif
  output logic [31:0] alu_operand_a_o,
  output logic [31:0] alu_operand_b_o,
  output logic [1:0]  alu_sub_o,
  output logic        alu_req_o,
  input  logic [32:0] alu_result_i,
  output logic [31:0] result_o,
  output logic        ov_o,
  output logic        valid_o,
  output logic        busy_o
);

  localparam int ACC_W = 64;

  typedef enum logic [2:0] {IDLE, ALBL, ALBH, AHBL, AHBH, ACC} state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;

  logic               hi_op;
  logic               a_hi, b_hi;
  logic [16:0]        mul_a, mul_b;
  logic signed [33:0] mul_prod;
  logic [ACC_W-1:0]   pp;
  logic [31:0]        word_hi;
  logic               sat;
  logic [31:0]        sat_res;

  assign hi_op = op_i[1];

  // Operand half selection follows the state: A-high in AHBL/AHBH,
  // B-high in ALBH/AHBH. Low halves are unsigned, high halves signed.
  assign a_hi  = (state_q == AHBL) || (state_q == AHBH);
  assign b_hi  = (state_q == ALBH) || (state_q == AHBH);
  assign mul_a = a_hi ? {operand_a_i[31], operand_a_i[31:16]} : {1'b0, operand_a_i[15:0]};
  assign mul_b = b_hi ? {operand_b_i[31], operand_b_i[31:16]} : {1'b0, operand_b_i[15:0]};

  assign mul_prod = $signed({{17{mul_a[16]}}, mul_a}) * $signed({{17{mul_b[16]}}, mul_b});
  assign pp       = {{(ACC_W-34){mul_prod[33]}}, mul_prod};

`ifdef IBEX_PEXT_MAC_ROUND_EN
  // Cannot wrap: acc[63:32]=0x7FFFFFFF with acc[31]=1 is not a reachable product.
  assign word_hi = acc_q[63:32] + {31'b0, round_i & acc_q[31]};
`else
  assign word_hi = acc_q[63:32];
`endif

  // 33-bit result overflows 32 bits when the two top bits disagree.
  assign sat     = alu_result_i[32] != alu_result_i[31];
  assign sat_res = alu_result_i[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;

  always_comb begin
    state_d         = state_q;
    acc_d           = acc_q;
    alu_req_o       = 1'b0;
    alu_operand_a_o = '0;
    alu_operand_b_o = '0;
    alu_sub_o       = 2'b00;
    valid_o         = 1'b0;
    result_o        = '0;
    ov_o            = 1'b0;
    unique case (state_q)
      IDLE: if (en_i) state_d = ALBL;
      ALBL: begin
        acc_d   = pp;
        state_d = ALBH;
      end
      ALBH: begin
        acc_d   = acc_q + (pp << 16);
        state_d = AHBL;
      end
      AHBL: begin
        acc_d   = acc_q + (pp << 16);
        // AH*BH only lands in bits 63:32, irrelevant to lo ops.
        state_d = hi_op ? AHBH : ACC;
      end
      AHBH: begin
        acc_d   = acc_q + (pp << 32);
        state_d = ACC;
      end
      ACC: begin
        alu_req_o       = 1'b1;
        alu_operand_a_o = operand_c_i;
        alu_operand_b_o = hi_op ? word_hi : acc_q[31:0];
        alu_sub_o       = {2{op_i[0]}};
        valid_o         = !kill_i;
        if (valid_o) begin
          result_o = (hi_op && sat) ? sat_res : alu_result_i[31:0];
          ov_o     = hi_op && sat;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Flush wins everywhere, including over a new request in IDLE.
    if (kill_i) begin
      state_d = IDLE;
      acc_d   = acc_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
    end
  end

  assign busy_o = state_q != IDLE;

`ifndef SYNTHESIS
  en_held_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q != IDLE) |-> (en_i || kill_i));
`endif

endmodule

// File: doc/ibex_pext_mac_sequencer.md
Name: ibex_pext_mac_sequencer

Overview:
Multi-cycle sequencer for the Pext 32-bit multiply-accumulate ops MADDR32, MSUBR32, KMMAC and KMMSB. It time-shares one internal signed 17x17 multiplier across four partial products and holds them in a 64-bit accumulator. It then borrows the shared ALU adder for the final add/sub with rd, and saturates where the op requires. It sits beside the ALU in the EX stage; the decoder raises en_i and the EX stage stalls until valid_o.

Parameters:
ACC_W, 64, accumulator width; fixed, not user-tunable; stated for verification.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
en_i  in  1  op request; held high and operands held stable until valid_o or kill_i
kill_i  in  1  abort the current op (EX flush)
op_i  in  2  00 MADDR32, 01 MSUBR32, 10 KMMAC, 11 KMMSB
operand_a_i  in  32  rs1
operand_b_i  in  32  rs2
operand_c_i  in  32  rd (accumulate source)
alu_operand_a_o  out  32  adder operand A (rd) during ACC, else 0
alu_operand_b_o  out  32  adder operand B (selected product word) during ACC, else 0
alu_sub_o  out  2  2'b11 for MSUBR32/KMMSB during ACC, else 2'b00
alu_req_o  out  1  high only in ACC; ALU mux hands the adder to this block
alu_result_i  in  33  sign-extended 33-bit adder result, combinational in the same cycle
result_o  out  32  final value, valid when valid_o
ov_o  out  1  saturation occurred (KMMAC/KMMSB only), valid with valid_o
valid_o  out  1  one-cycle completion strobe
busy_o  out  1  high in any non-IDLE state

Behaviour:
- Reset: state IDLE, accumulator 0; all outputs 0.
- States: IDLE, ALBL, ALBH, AHBL, AHBH, ACC.
- IDLE -> ALBL when en_i && !kill_i. The first partial product is computed in ALBL, the cycle after the request is sampled.
- Partial products. Low halves are zero-extended to 17 bits; high halves are sign-extended.
  - ALBL: acc = AL*BL.
  - ALBH: acc += (AL*BH) << 16.
  - AHBL: acc += (AH*BL) << 16.
  - AHBH: acc += (AH*BH) << 32.
  - Accumulation is 64-bit two's complement, wrap-around.
- Sequence by op:
  - MADDR32/MSUBR32: AHBL -> ACC. AHBH is skipped because it cannot affect the low 32 bits.
  - KMMAC/KMMSB: AHBL -> AHBH -> ACC.
- ACC:
  - alu_req_o=1; alu_operand_a_o=operand_c_i.
  - alu_operand_b_o = acc[31:0] for lo ops, acc[63:32] for hi ops.
  - valid_o=1, combinational in the same cycle; next state IDLE.
- Latency from the first cycle en_i is high to valid_o:
  - lo ops: 5 cycles (IDLE, ALBL, ALBH, AHBL, ACC);
  - hi ops: 6 cycles.
  - Back-to-back ops restart from IDLE the cycle after ACC. There is no skip.
- Result:
  - Lo ops: result_o = alu_result_i[31:0], ov_o=0.
  - Hi ops: if alu_result_i[32] != alu_result_i[31], clamp to 0x7FFFFFFF (bit32=0) or 0x80000000 (bit32=1) and set ov_o=1. Otherwise pass [31:0] through with ov_o=0.
- kill_i in any state: next state IDLE, no valid_o, accumulator left stale. kill_i has priority over en_i in IDLE.
- en_i dropping mid-op without kill_i is illegal; an assertion flags it.
- Asynchronous reset mid-op: immediate IDLE, all outputs 0.
- alu_result_i is ignored outside ACC.

Optional Feature:
- Macro: IBEX_PEXT_MAC_ROUND_EN.
- When defined:
  - Adds input round_i (1 bit), sampled with op_i. It selects the rounding variants KMMACu/KMMSBu.
  - For hi ops with round_i=1, alu_operand_b_o = acc[63:32] + acc[31].
  - The +1 is added by this block before ACC; it does not wrap, because acc[63:32]=0x7FFFFFFF with acc[31]=1 is unreachable.
  - round_i is ignored for lo ops.
- When undefined: no round_i port; truncation only.

Test Plan:
- MADDR32, a=3, b=5, c=10 -> valid_o on cycle 5, result_o=25, ov_o=0, alu_sub_o=00 in ACC.
- MSUBR32, a=0x00010000, b=0x00010000, c=7 -> lo32 of product is 0; result_o=7, alu_sub_o=11, latency 5.
- KMMAC, a=0x40000000, b=0x40000000 (hi32=0x10000000), c=0x7FFFFFF0 -> result_o=0x7FFFFFFF, ov_o=1, valid_o on cycle 6.
- KMMSB, a=0x80000000, b=0x80000000 (hi32=0x40000000), c=0x80000000 -> result_o=0x80000000, ov_o=1.
- kill_i pulsed in AHBL of a KMMAC -> no valid_o; busy_o=0 the next cycle; an immediately following MADDR32 (3, 5, 10) returns 25.
- With IBEX_PEXT_MAC_ROUND_EN: KMMAC, round_i=1, a=0xFFFFFFFF, b=0x80000000 (product 0x00000000_80000000), c=0 -> result_o=1. With round_i=0 -> result_o=0.
